// File: rtl/cordic_pkg.sv
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Constants, default Q format and FSM state type shared by the
//            fixed/float converters on the CORDIC datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

    localparam int FP_BIAS     = 127;
    localparam int FP_MAN_BITS = 23;
    localparam int FP_EXP_BITS = 8;

    // Q2.30 result format of the CORDIC core
    localparam int Q_WIDTH     = 32;
    localparam int Q_FRAC_BITS = 30;

    // 1/K (CORDIC gain compensation) in Q2.30
    localparam logic [31:0] INV_K_Q230 = 32'h26DD3B6A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_pack.sv
// ============================================================================
// Module   : fp_pack
// Purpose  : Combinational packer from a normalised magnitude and shift count
//            to IEEE-754 single. FIX2FLT_RNE_EN selects round-to-nearest-even,
//            otherwise the result is truncated toward zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_pack
    import cordic_pkg::*;
#(
    parameter int WIDTH     = Q_WIDTH,
    parameter int FRAC_BITS = Q_FRAC_BITS,
    parameter int LZ_BITS   = $clog2(WIDTH) + 1
) (
    input  logic               sign,
    input  logic [WIDTH-1:0]   mag,
    input  logic [LZ_BITS-1:0] lz,
    output logic [31:0]        flt
);

    localparam int BODY_BITS = FP_EXP_BITS + FP_MAN_BITS;
    localparam int EXP_OFS   = FP_BIAS + WIDTH - 1 - FRAC_BITS;

    logic [FP_EXP_BITS-1:0] exp_raw;
    logic [FP_MAN_BITS-1:0] frac_raw;
    logic [BODY_BITS-1:0]   body;

    // mag[WIDTH-1] is the implied leading one once normalised
    assign exp_raw  = FP_EXP_BITS'(EXP_OFS) - FP_EXP_BITS'(lz);
    assign frac_raw = mag[WIDTH-2 -: FP_MAN_BITS];

`ifdef FIX2FLT_RNE_EN
    logic guard;
    logic sticky;
    logic round_up;

    assign guard    = mag[WIDTH-FP_MAN_BITS-2];
    assign sticky   = |mag[WIDTH-FP_MAN_BITS-3:0];
    assign round_up = guard & (sticky | frac_raw[0]);
    // A fraction carry ripples into the exponent and clears the fraction
    assign body     = {exp_raw, frac_raw} + BODY_BITS'(round_up);
`else
    assign body     = {exp_raw, frac_raw};
`endif

    assign flt = (mag == '0) ? 32'h0000_0000 : {sign, body};

endmodule

`default_nettype wire

// File: rtl/fixed_to_float.sv
// ============================================================================
// Module   : fixed_to_float
// Purpose  : Multi-cycle signed fixed-point to IEEE-754 single converter with
//            a one-shift-per-cycle normaliser and start/done handshake.
//            FIX2FLT_RNE_EN enables round-to-nearest-even in fp_pack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_to_float
    import cordic_pkg::*;
#(
    parameter int WIDTH     = Q_WIDTH,
    parameter int FRAC_BITS = Q_FRAC_BITS
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    output logic             done,
    output logic [31:0]      result
);

    localparam int LZ_BITS = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_nx;
    logic               sign;
    logic               sign_nx;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   mag_nx;
    logic [LZ_BITS-1:0] lz;
    logic [LZ_BITS-1:0] lz_nx;
    logic               done_nx;
    logic [31:0]        result_nx;
    logic [31:0]        packed_flt;

    fp_pack #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .LZ_BITS   (LZ_BITS)
    ) u_fp_pack (
        .sign (sign),
        .mag  (mag),
        .lz   (lz),
        .flt  (packed_flt)
    );

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state  <= IDLE;
            sign   <= 1'b0;
            mag    <= '0;
            lz     <= '0;
            done   <= 1'b0;
            result <= 32'h0000_0000;
        end else if (clk_en) begin
            state  <= state_nx;
            sign   <= sign_nx;
            mag    <= mag_nx;
            lz     <= lz_nx;
            done   <= done_nx;
            result <= result_nx;
        end else begin
            // A stalled cycle never extends a done pulse
            done   <= 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        sign_nx   = sign;
        mag_nx    = mag;
        lz_nx     = lz;
        done_nx   = 1'b0;
        result_nx = result;

        case (state)
            IDLE: begin
                if (start) begin
                    sign_nx  = dataa[WIDTH-1];
                    // Unsigned magnitude: the most negative input maps to 2^(WIDTH-1)
                    mag_nx   = dataa[WIDTH-1] ? (~dataa + WIDTH'(1)) : dataa;
                    lz_nx    = '0;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if ((mag == '0) || mag[WIDTH-1]) begin
                    state_nx = PACK;
                end else begin
                    mag_nx = mag << 1;
                    lz_nx  = lz + LZ_BITS'(1);
                end
            end
            PACK: begin
                result_nx = packed_flt;
                done_nx   = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/fixed_to_float.md
Name: fixed_to_float

Overview:
- Multi-cycle converter from signed fixed-point to IEEE-754 single precision.
- It is the encode direction for the float-to-fixed decode at the CORDIC input. It takes the Q2.30 cosine/sine result from the CORDIC core and produces a 32-bit float on `result`.
- Uses an iterative normaliser (one left shift per cycle) under a start/done handshake, compatible with the multi-cycle custom-instruction slot.

Parameters:
- WIDTH, 32, fixed-point input width (two's complement).
- FRAC_BITS, 30, number of fractional bits in the input (Q2.30 by default).

Ports:
- clock  in  1  sole clock, rising edge.
- aclr  in  1  asynchronous active-high reset.
- clk_en  in  1  clock enable; when low, all registers hold and start is ignored.
- start  in  1  one-cycle request; samples dataa.
- dataa  in  WIDTH  signed fixed-point operand.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  IEEE-754 single; held until the next done.

Behaviour:
- Reset (aclr high, asynchronous): state=IDLE, done=0, result=32'h0, internal magnitude/count=0. Reset mid-conversion aborts it; no done is issued.
- FSM IDLE:
  - start&clk_en: sign<=dataa[WIDTH-1]; mag<=|dataa| as an unsigned WIDTH-bit value (0x80000000 gives magnitude 2^31, no overflow); shift count lz<=0; go to NORM.
- FSM NORM, each enabled cycle:
  - If mag==0 or mag[WIDTH-1]==1, go to PACK.
  - Else mag<=mag<<1, lz<=lz+1.
- FSM PACK:
  - Register result; done<=1 for exactly one cycle; return to IDLE.
  - done is deasserted in every other cycle.
- Latency from the start edge to done high: 2+lz cycles for nonzero input (lz = leading zeros of the magnitude), 2 for zero. Maximum is 33.
- start while not IDLE is ignored; there is no queueing.
- Packing:
  - Zero gives +0.0 (32'h00000000) regardless of sign.
  - exp = 127 + (WIDTH-1-lz) - FRAC_BITS, 8 bits. This is always within 1..254 for the defaults; no denormal or inf path is needed.
  - fraction = mag[WIDTH-2 -: 23].
  - Remaining low bits form guard (mag[WIDTH-25]) and sticky (OR of the bits below it).
- Default rounding (macro absent) is truncation: guard/sticky are discarded.
- clk_en low: FSM, counters and outputs freeze. A done pulse pending in PACK is delayed until clk_en returns; done is not stretched.

Optional Feature:
- Macro FIX2FLT_RNE_EN.
- Defined: round-to-nearest-even in PACK. Increment {exp,fraction} when guard & (sticky | fraction[0]). A carry out of the fraction increments exp and clears the fraction. Latency is unchanged.
- Undefined: truncation toward zero as above. No guard/sticky logic is synthesised.

Decomposition:
- Shared package (cordic_pkg) holds:
  - constants FP_BIAS=127, FP_MAN_BITS=23, FP_EXP_BITS=8;
  - the default Q format (WIDTH, FRAC_BITS);
  - the FSM state enum {IDLE, NORM, PACK};
  - the Q2.30 constant for 1/K.
- One natural sub-module: fp_pack. It is combinational: sign, mag, lz in; packed float out; it contains the rounding. It is reusable by the float-to-fixed side's test models.

Test Plan:
- Reset/idle: aclr pulse mid-NORM (dataa=0x00000001 in flight) -> done never asserts; result=0x00000000; next start works normally.
- Exact values: 0x40000000 -> 0x3F800000 (done 3 cycles after start); 0x20000000 -> 0x3F000000; 0xC0000000 -> 0xBF800000; 0x80000000 -> 0xC0000000.
- Zero and extreme shift: 0x00000000 -> 0x00000000 after 2 cycles; 0x00000001 -> 0x30800000 after 33 cycles.
- Rounding: 0x7FFFFFFF -> 0x40000000 with FIX2FLT_RNE_EN, 0x3FFFFFFF without it. CORDIC gain 0x26DD3B6A -> 0x3F1B74EE.
- Handshake: start held high/re-pulsed during NORM -> ignored, single done. clk_en low for 5 cycles during NORM -> latency extended by exactly 5, result unchanged.
- Back-to-back: start asserted in the cycle after done -> second conversion is accepted and correct; done pulses are each exactly one cycle wide.
